accumulator_sequencer: RTL and testbench

Accumulator register and operation sequencer for the Manchester Baby datapath, sitting directly downstream of the ALU. It drives the ALU operand, SUB and OE_n inputs and waits a fixed number of clocks for the ripple-carry TTL adder to settle. It then captures the ALU RESULT bus into the 32-bit accumulator. It executes the Baby accumulator instructions LDN, SUB, STO and CMP under a start/done handshake from the control unit.

---
 rtl/accumulator_sequencer_if.sv | 38 +++
 rtl/accumulator_sequencer.sv | 151 +++++++++++++++
 tb/tb_accumulator_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accumulator_sequencer_if.sv
// Control-unit / ALU side signal bundle for accumulator_sequencer.
// ZERO is present only when ACCUMULATOR_ZERO_FLAG_EN is defined.
interface accumulator_sequencer_if;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] OPERAND;
  logic [31:0] ALU_RESULT;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic        ALU_SUB;
  logic        ALU_OE_n;
  logic        BUSY;
  logic        DONE;
  logic        SKIP;
  logic [31:0] ACC;
  logic        NEG;
`ifdef ACCUMULATOR_ZERO_FLAG_EN
  logic        ZERO;

  modport master (
    output START, OP, OPERAND, ALU_RESULT,
    input  ALU_A, ALU_B, ALU_SUB, ALU_OE_n, BUSY, DONE, SKIP, ACC, NEG, ZERO
  );
  modport slave (
    input  START, OP, OPERAND, ALU_RESULT,
    output ALU_A, ALU_B, ALU_SUB, ALU_OE_n, BUSY, DONE, SKIP, ACC, NEG, ZERO
  );
`else
  modport master (
    output START, OP, OPERAND, ALU_RESULT,
    input  ALU_A, ALU_B, ALU_SUB, ALU_OE_n, BUSY, DONE, SKIP, ACC, NEG
  );
  modport slave (
    input  START, OP, OPERAND, ALU_RESULT,
    output ALU_A, ALU_B, ALU_SUB, ALU_OE_n, BUSY, DONE, SKIP, ACC, NEG
  );
`endif
endinterface

// File: rtl/accumulator_sequencer.sv
// Manchester Baby accumulator and LDN/SUB/STO/CMP sequencer driving a slow ripple ALU.
// Optional ZERO flag and skip-if-ACC<=0 CMP enabled by macro ACCUMULATOR_ZERO_FLAG_EN.
module accumulator_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  accumulator_sequencer_if.slave seq,
  output wire  [31:0]            ACC_BUS
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("accumulator_sequencer: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [1:0] OP_LDN  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_STO  = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;
  localparam logic [3:0] LP_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_to_alu;
  logic        w_cmp_flag;
  logic [3:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_neg;
  logic        r_alu_sub;
  logic        r_alu_oe_n;
  logic        r_skip;
  logic        r_sto_en;
`ifdef ACCUMULATOR_ZERO_FLAG_EN
  logic        r_zero;

  assign w_cmp_flag = r_neg | r_zero;
  assign seq.ZERO   = r_zero;
`else
  assign w_cmp_flag = r_neg;
`endif

  // The DONE cycle (FINISH) also accepts START so a held START issues back-to-back.
  always_comb begin
    w_accept = 1'b0;
    w_next   = r_state;
    case (r_state)
      S_IDLE, S_FINISH: begin
        if (seq.START) begin
          w_accept = 1'b1;
          if (seq.OP == OP_LDN || seq.OP == OP_SUB) begin
            w_next = S_DRIVE;
          end else begin
            w_next = S_FINISH;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (r_cnt == LP_LAST) begin
          w_next = S_CAPTURE;
        end else begin
          w_next = S_DRIVE;
        end
      end
      S_CAPTURE: w_next = S_FINISH;
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_to_alu = (w_next == S_DRIVE) || (w_next == S_CAPTURE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_acc      <= 32'd0;
      r_neg      <= 1'b0;
      r_alu_a    <= 32'd0;
      r_alu_b    <= 32'd0;
      r_alu_sub  <= 1'b0;
      r_alu_oe_n <= 1'b1;
      r_skip     <= 1'b0;
      r_sto_en   <= 1'b0;
`ifdef ACCUMULATOR_ZERO_FLAG_EN
      r_zero     <= 1'b1;
`endif
    end else begin
      r_state    <= w_next;
      r_alu_oe_n <= ~w_to_alu;
      r_skip     <= w_accept && (seq.OP == OP_CMP) && w_cmp_flag;
      r_sto_en   <= w_accept && (seq.OP == OP_STO);

      if (r_state == S_DRIVE && r_cnt != LP_LAST) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end

      // Operands latch on DRIVE entry and stay frozen while the adder settles.
      if (w_accept && w_next == S_DRIVE) begin
        r_alu_a   <= (seq.OP == OP_SUB) ? r_acc : 32'd0;
        r_alu_b   <= seq.OPERAND;
        r_alu_sub <= 1'b1;
      end else if (!w_to_alu) begin
        r_alu_a   <= 32'd0;
        r_alu_b   <= 32'd0;
        r_alu_sub <= 1'b0;
      end else begin
        r_alu_a   <= r_alu_a;
        r_alu_b   <= r_alu_b;
        r_alu_sub <= r_alu_sub;
      end

      if (r_state == S_CAPTURE) begin
        r_acc <= seq.ALU_RESULT;
        r_neg <= seq.ALU_RESULT[31];
`ifdef ACCUMULATOR_ZERO_FLAG_EN
        r_zero <= (seq.ALU_RESULT == 32'd0);
`endif
      end else begin
        r_acc <= r_acc;
        r_neg <= r_neg;
      end
    end
  end

  assign seq.ALU_A    = r_alu_a;
  assign seq.ALU_B    = r_alu_b;
  assign seq.ALU_SUB  = r_alu_sub;
  assign seq.ALU_OE_n = r_alu_oe_n;
  assign seq.BUSY     = (r_state != S_IDLE);
  assign seq.DONE     = (r_state == S_FINISH);
  assign seq.SKIP     = r_skip;
  assign seq.ACC      = r_acc;
  assign seq.NEG      = r_neg;
  assign ACC_BUS      = r_sto_en ? r_acc : {32{1'bz}};

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Scoreboard bench for accumulator_sequencer: directed test-plan cases plus random traffic.
module tb_accumulator_sequencer;
  localparam int S = 4;
  localparam logic [1:0] LDN = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] STO = 2'b10;
  localparam logic [1:0] CMP = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] acc;
    logic        skip;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    int          acc_cyc;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [31:0] acc_bus;
  logic [31:0] junk = 32'h0;
  accumulator_sequencer_if bus_if ();

  accumulator_sequencer #(.SETTLE_CYCLES(S)) dut (
    .CLK     (clk),
    .RESET   (rst),
    .seq     (bus_if.slave),
    .ACC_BUS (acc_bus)
  );

  always #5 clk = ~clk;

  // ALU stand-in: real result while enabled, garbage while its output is off.
  always @(posedge clk) junk <= $urandom;
  assign bus_if.ALU_RESULT = bus_if.ALU_OE_n ? junk :
                             (bus_if.ALU_SUB ? bus_if.ALU_A - bus_if.ALU_B
                                             : bus_if.ALU_A + bus_if.ALU_B);

  exp_t        q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] model_acc = 32'h0;
  logic [31:0] committed = 32'h0;
  bit          in_reset = 1'b1;
  bit          hold_start = 1'b0;
  int          busy_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Undriven bus reads as Z in 4-state simulators and as 0 in 2-state ones.
  task automatic chk_released(input string name, input logic [31:0] act);
    n_chk++;
    if (!(act === {32{1'bz}} || act === 32'h0)) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected released (Z)", name, cyc, act);
    end
  endtask

  function automatic logic cmp_flag(input logic [31:0] a);
`ifdef ACCUMULATOR_ZERO_FLAG_EN
    return a[31] || (a == 32'h0);
`else
    return a[31];
`endif
  endfunction

  // Monitor: compares every cycle against the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t        f;
    bit          have, active, in_drive, done_exp;
    logic [31:0] acc_now;
    if (in_reset) begin
      committed = 32'h0;
    end else begin
      have = (q.size() > 0);
      if (have) f = q[0];
      active   = have && (f.acc_cyc <= cyc);
      in_drive = active && (f.op == LDN || f.op == SUB) && (cyc <= f.acc_cyc + S);
      done_exp = active && (f.done_cyc == cyc);
      acc_now  = done_exp ? f.acc : committed;
      chk1("busy", bus_if.BUSY, active);
      chk1("alu_oe_n", bus_if.ALU_OE_n, !in_drive);
      if (in_drive) begin
        chk32("alu_a", bus_if.ALU_A, f.alu_a);
        chk32("alu_b", bus_if.ALU_B, f.alu_b);
        chk1("alu_sub", bus_if.ALU_SUB, 1'b1);
      end else if (!active) begin
        chk32("alu_a_idle", bus_if.ALU_A, 32'h0);
        chk32("alu_b_idle", bus_if.ALU_B, 32'h0);
        chk1("alu_sub_idle", bus_if.ALU_SUB, 1'b0);
      end
      chk1("done", bus_if.DONE, done_exp);
      chk32("acc", bus_if.ACC, acc_now);
      chk1("neg", bus_if.NEG, acc_now[31]);
`ifdef ACCUMULATOR_ZERO_FLAG_EN
      chk1("zero", bus_if.ZERO, acc_now == 32'h0);
`endif
      chk1("skip", bus_if.SKIP, done_exp && f.skip);
      if (done_exp && f.op == STO) chk32("acc_bus_sto", acc_bus, acc_now);
      else chk_released("acc_bus_z", acc_bus);
      if (done_exp) begin
        committed = f.acc;
        void'(q.pop_front());
      end
    end
  end

  // One driver cycle; issues only when the model says the DUT is idle or in its DONE cycle.
  task automatic drive_cycle(input bit want, input logic [1:0] op, input logic [31:0] opnd,
                             output bit issued);
    exp_t e;
    int   lat;
    @(negedge clk);
    issued = 1'b0;
    if (busy_left == 0) begin
      if (want) begin
        bus_if.START   = 1'b1;
        bus_if.OP      = op;
        bus_if.OPERAND = opnd;
        e.op    = op;
        e.alu_a = 32'h0;
        e.alu_b = opnd;
        e.skip  = 1'b0;
        case (op)
          LDN: model_acc = 32'h0 - opnd;
          SUB: begin
            e.alu_a   = model_acc;
            model_acc = model_acc - opnd;
          end
          CMP: e.skip = cmp_flag(model_acc);
          default: ;
        endcase
        e.acc      = model_acc;
        lat        = (op == LDN || op == SUB) ? S + 1 : 0;
        e.acc_cyc  = cyc + 1;
        e.done_cyc = cyc + 1 + lat;
        q.push_back(e);
        busy_left = lat;
        issued    = 1'b1;
      end else begin
        bus_if.START   = 1'b0;
        bus_if.OP      = 2'($urandom);
        bus_if.OPERAND = $urandom;
      end
    end else begin
      busy_left--;
      bus_if.START   = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
      bus_if.OP      = 2'($urandom);
      bus_if.OPERAND = $urandom;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] opnd);
    bit issued = 1'b0;
    for (int k = 0; k < 40 && !issued; k++) drive_cycle(1'b1, op, opnd, issued);
    n_chk++;
    if (!issued) begin
      n_fail++;
      $display("FAIL issue_timeout: op %0d never issued", op);
    end
  endtask

  task automatic idle(input int n);
    bit issued;
    for (int k = 0; k < n; k++) drive_cycle(1'b0, LDN, 32'h0, issued);
  endtask

  task automatic check_reset_state();
    chk32("rst_acc", bus_if.ACC, 32'h0);
    chk1("rst_neg", bus_if.NEG, 1'b0);
    chk1("rst_busy", bus_if.BUSY, 1'b0);
    chk1("rst_done", bus_if.DONE, 1'b0);
    chk1("rst_skip", bus_if.SKIP, 1'b0);
    chk1("rst_oe_n", bus_if.ALU_OE_n, 1'b1);
    chk32("rst_alu_a", bus_if.ALU_A, 32'h0);
    chk1("rst_alu_sub", bus_if.ALU_SUB, 1'b0);
    chk_released("rst_acc_bus", acc_bus);
`ifdef ACCUMULATOR_ZERO_FLAG_EN
    chk1("rst_zero", bus_if.ZERO, 1'b1);
`endif
  endtask

  // Mid-cycle reset with START=LDN asserted alongside to show reset priority.
  task automatic do_reset();
    @(posedge clk);
    #1;
    in_reset       = 1'b1;
    rst            = 1'b1;
    bus_if.START   = 1'b1;
    bus_if.OP      = LDN;
    bus_if.OPERAND = 32'h1234_5678;
    q.delete();
    model_acc = 32'h0;
    busy_left = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    bus_if.START = 1'b0;
    check_reset_state();
    in_reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [1:0]  op;
    logic [31:0] opnd;
    bus_if.START   = 1'b0;
    bus_if.OP      = LDN;
    bus_if.OPERAND = 32'h0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    in_reset = 1'b0;

    run_op(LDN, 32'h0000_0005);
    idle(S + 3);
    chk32("ldn5_acc", bus_if.ACC, 32'hFFFF_FFFB);
    chk1("ldn5_neg", bus_if.NEG, 1'b1);
    run_op(CMP, 32'h0);
    run_op(STO, 32'h0);
    idle(3);

    hold_start = 1'b1;
    run_op(LDN, 32'h0000_000A);
    run_op(SUB, 32'hFFFF_FFF0);
    hold_start = 1'b0;
    idle(S + 3);
    chk32("sub_chain_acc", bus_if.ACC, 32'h0000_0006);
    chk1("sub_chain_neg", bus_if.NEG, 1'b0);

    hold_start = 1'b1;
    run_op(LDN, 32'h0000_0001);
    run_op(LDN, 32'h8000_0000);
    hold_start = 1'b0;
    idle(S + 3);
    chk32("wrap_acc", bus_if.ACC, 32'h8000_0000);
    chk1("wrap_neg", bus_if.NEG, 1'b1);
`ifdef ACCUMULATOR_ZERO_FLAG_EN
    run_op(SUB, 32'h8000_0000);
    run_op(CMP, 32'h0);
    idle(S + 3);
    chk32("zero_acc", bus_if.ACC, 32'h0);
    chk1("zero_flag", bus_if.ZERO, 1'b1);
`endif

    for (int t = 0; t < 120; t++) begin
      op   = 2'($urandom);
      opnd = ($urandom_range(0, 7) == 0) ? model_acc : $urandom;
      hold_start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) run_op(op, opnd);
      else idle($urandom_range(1, 3));
    end
    hold_start = 1'b0;
    idle(S + 3);

    run_op(LDN, 32'h0000_0003);
    run_op(SUB, 32'h0000_0007);
    idle(2);
    do_reset();
    idle(2 * S + 6);

    run_op(SUB, 32'h0000_0001);
    run_op(CMP, 32'h0);
    run_op(STO, 32'h0);
    idle(S + 4);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected completions still pending", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
